// File: rtl/id_ctrl_pipe.sv
// rtl/id_ctrl_pipe.sv - RV32I decode stage with ID/EX register, load-use stall FSM and flush.
// Optional CSR decode is enabled by defining CSR_EN.
module id_ctrl_pipe #(
  parameter int STALL_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  mem_write,
  output logic        illegal
`ifdef CSR_EN
  ,
  output logic        csr_we,
  output logic [11:0] csr_addr
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  mem_write;
    logic        illegal;
`ifdef CSR_EN
    logic        csr_we;
    logic [11:0] csr_addr;
`endif
  } idex_t;

  typedef enum logic {RUN, STALL} state_t;

  idex_t  dec, q;
  logic   valid_q;
  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic   use_rs1, use_rs2, hazard, load_new, hold;

  always_comb begin
    dec = '0;
    dec.opcode = instruction[6:0];
    dec.rd     = instruction[11:7];
    dec.funct3 = instruction[14:12];
    dec.rs1    = instruction[19:15];
    dec.rs2    = instruction[24:20];
    dec.funct7 = instruction[31:25];
    case (instruction[6:0])
      OP_LUI, OP_AUIPC, OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec.branch    = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_src = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        case (instruction[14:12])
          3'b000:  begin dec.alu_src = 1'b1; dec.mem_write = 2'd1; end
          3'b001:  begin dec.alu_src = 1'b1; dec.mem_write = 2'd2; end
          3'b010:  begin dec.alu_src = 1'b1; dec.mem_write = 2'd3; end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_OP: dec.reg_write = 1'b1;
      OP_SYSTEM: begin
`ifdef CSR_EN
        // read-only CSR forms (set/clear with x0 source) must not write the CSR
        if (instruction[14:12] == 3'b100) begin
          dec.illegal = 1'b1;
        end else if (instruction[14:12] != 3'b000) begin
          dec.reg_write = 1'b1;
          dec.csr_addr  = instruction[31:20];
          dec.csr_we    = !(instruction[13] && instruction[19:15] == 5'd0);
        end
`endif
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign use_rs1 = !(instruction[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign use_rs2 = instruction[6:0] inside {OP_BRANCH, OP_STORE, OP_OP};
  assign hazard  = in_valid && valid_q && q.mem_read && (q.rd != 5'd0) &&
                   ((use_rs1 && q.rd == instruction[19:15]) ||
                    (use_rs2 && q.rd == instruction[24:20]));

  assign in_ready = rst_n && (state == RUN) && !hazard && !flush && (!valid_q || out_ready);
  assign load_new = in_valid && in_ready;
  assign hold     = valid_q && !out_ready && !flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
    end else begin
      case (state)
        RUN: begin
          // the hazard cycle itself is bubble 1, so only the remainder is counted here
          if (hazard && out_ready && STALL_CYC > 1) begin
            state_nxt = STALL;
            cnt_nxt   = 2'(STALL_CYC - 1);
          end
        end
        STALL: begin
          cnt_nxt = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
          if (cnt <= 2'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 2'd0;
      valid_q <= 1'b0;
      q       <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_new) begin
        valid_q <= 1'b1;
        q       <= dec;
      end else if (!hold) begin
        valid_q <= 1'b0;
        q       <= '0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign opcode     = q.opcode;
  assign rd         = q.rd;
  assign rs1        = q.rs1;
  assign rs2        = q.rs2;
  assign funct3     = q.funct3;
  assign funct7     = q.funct7;
  assign branch     = q.branch;
  assign mem_read   = q.mem_read;
  assign mem_to_reg = q.mem_to_reg;
  assign alu_src    = q.alu_src;
  assign reg_write  = q.reg_write;
  assign mem_write  = q.mem_write;
  assign illegal    = q.illegal;
`ifdef CSR_EN
  assign csr_we     = q.csr_we;
  assign csr_addr   = q.csr_addr;
`endif

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// tb/tb_id_ctrl_pipe.sv - self-checking bench for id_ctrl_pipe (STALL_CYC 1 and 3 instances).
// CSR checks are compiled in when CSR_EN is defined.
module tb_id_ctrl_pipe;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  ctl;   // {branch, mem_read, mem_to_reg, alu_src, reg_write}
    logic [1:0]  mw;
    logic        ill;
    logic        cwe;
    logic [11:0] caddr;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [4:0]  ctl;
    logic [1:0]  mw;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid[2], flush[2], out_ready[2];
  logic [31:0] ins[2];
  logic        in_ready[2], out_valid[2];
  logic [6:0]  opcode[2], funct7[2];
  logic [4:0]  rd[2], rs1[2], rs2[2];
  logic [2:0]  funct3[2];
  logic        branch[2], mem_read[2], mem_to_reg[2], alu_src[2], reg_write[2], illegal[2];
  logic [1:0]  mem_write[2];
  logic        csr_we[2];
  logic [11:0] csr_addr[2];
  out_t        got[2];

  int errors = 0;
  int checks = 0;

  id_ctrl_pipe #(.STALL_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .instruction(ins[0]), .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .opcode(opcode[0]), .rd(rd[0]), .rs1(rs1[0]), .rs2(rs2[0]), .funct3(funct3[0]),
    .funct7(funct7[0]), .branch(branch[0]), .mem_read(mem_read[0]), .mem_to_reg(mem_to_reg[0]),
    .alu_src(alu_src[0]), .reg_write(reg_write[0]), .mem_write(mem_write[0]), .illegal(illegal[0])
`ifdef CSR_EN
    , .csr_we(csr_we[0]), .csr_addr(csr_addr[0])
`endif
  );

  id_ctrl_pipe #(.STALL_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .instruction(ins[1]), .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .opcode(opcode[1]), .rd(rd[1]), .rs1(rs1[1]), .rs2(rs2[1]), .funct3(funct3[1]),
    .funct7(funct7[1]), .branch(branch[1]), .mem_read(mem_read[1]), .mem_to_reg(mem_to_reg[1]),
    .alu_src(alu_src[1]), .reg_write(reg_write[1]), .mem_write(mem_write[1]), .illegal(illegal[1])
`ifdef CSR_EN
    , .csr_we(csr_we[1]), .csr_addr(csr_addr[1])
`endif
  );

`ifndef CSR_EN
  always_comb begin
    csr_we[0] = 1'b0; csr_we[1] = 1'b0;
    csr_addr[0] = 12'd0; csr_addr[1] = 12'd0;
  end
`endif

  always_comb begin
    for (int k = 0; k < 2; k++)
      got[k] = {opcode[k], rd[k], rs1[k], rs2[k], funct3[k], funct7[k],
                branch[k], mem_read[k], mem_to_reg[k], alu_src[k], reg_write[k],
                mem_write[k], illegal[k], csr_we[k], csr_addr[k]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decoded expectation straight from the opcode table.
  function automatic out_t decode(input logic [31:0] w);
    out_t o = '0;
    o.op = w[6:0]; o.rd = w[11:7]; o.f3 = w[14:12];
    o.rs1 = w[19:15]; o.rs2 = w[24:20]; o.f7 = w[31:25];
    case (w[6:0])
      7'h37, 7'h17, 7'h13: o.ctl = 5'b00011;
      7'h6F, 7'h67:        o.ctl = 5'b10011;
      7'h63:               o.ctl = 5'b10010;
      7'h03:               o.ctl = 5'b01111;
      7'h23: if (w[14:12] <= 3'd2) begin
               o.ctl = 5'b00010;
               o.mw  = w[13:12] + 2'd1;
             end else o.ill = 1'b1;
      7'h33:               o.ctl = 5'b00001;
      7'h73: begin
`ifdef CSR_EN
        if (w[14:12] == 3'd4) o.ill = 1'b1;
        else if (w[14:12] != 3'd0) begin
          o.ctl   = 5'b00001;
          o.caddr = w[31:20];
          o.cwe   = !((w[14:12] inside {3'd2, 3'd3, 3'd6, 3'd7}) && w[19:15] == 5'd0);
        end
`endif
      end
      default: o.ill = 1'b1;
    endcase
    if (o.rd == 5'd0) o.ctl[0] = 1'b0;
    return o;
  endfunction

  logic m_valid[2];
  out_t m_q[2];
  int   m_left[2];
  int   stall_n[2] = '{1, 3};

  function automatic logic m_hazard(input int k);
    logic [6:0] op = ins[k][6:0];
    logic r1 = !(op inside {7'h37, 7'h17, 7'h6F});
    logic r2 = op inside {7'h63, 7'h23, 7'h33};
    return in_valid[k] && m_valid[k] && m_q[k].ctl[3] && m_q[k].rd != 5'd0 &&
           ((r1 && m_q[k].rd == ins[k][19:15]) || (r2 && m_q[k].rd == ins[k][24:20]));
  endfunction

  function automatic logic m_ready(input int k);
    return rst_n && m_left[k] == 0 && !m_hazard(k) && !flush[k] && (!m_valid[k] || out_ready[k]);
  endfunction

  task automatic model_step(input int k);
    logic rdy = m_ready(k);
    logic hz  = m_hazard(k);
    if (flush[k]) begin
      m_valid[k] = 1'b0; m_q[k] = '0; m_left[k] = 0;
    end else if (in_valid[k] && rdy) begin
      m_valid[k] = 1'b1; m_q[k] = decode(ins[k]);
    end else if (m_valid[k] && !out_ready[k]) begin
      // held
    end else if (hz) begin
      m_valid[k] = 1'b0; m_q[k] = '0; m_left[k] = stall_n[k] - 1;
    end else begin
      if (m_left[k] > 0) m_left[k]--;
      m_valid[k] = 1'b0; m_q[k] = '0;
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0] ops[12] = '{7'h37, 7'h17, 7'h13, 7'h6F, 7'h67, 7'h63,
                            7'h03, 7'h03, 7'h23, 7'h33, 7'h73, 7'h7F};
    logic [6:0] op = ops[$urandom_range(0, 11)];
    logic [4:0] r_d = 5'($urandom_range(0, 3));
    logic [4:0] r_1 = 5'($urandom_range(0, 3));
    logic [4:0] r_2 = 5'($urandom_range(0, 3));
    logic [2:0] f3  = 3'($urandom_range(0, 7));
    logic [6:0] f7  = 7'($urandom_range(0, 127));
    return {f7, r_2, r_1, f3, r_d, op};
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b1; ins[k] = 32'h0;
    end
  endtask

  task automatic load_use(input int k, input logic [31:0] lw, input logic [31:0] use_ins,
                          input int exp_bub, input string tag);
    int  stalls = 0;
    logic done = 1'b0;
    in_valid[k] = 1'b1; ins[k] = lw; out_ready[k] = 1'b1;
    @(negedge clk);
    chk({tag, " lw accepted"}, in_ready[k], 1'b1);
    tick();
    chk({tag, " lw in idex"}, {out_valid[k], mem_read[k]}, 2'b11);
    ins[k] = use_ins;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (in_ready[k]) done = 1'b1;
      else stalls++;
      tick();
      if (!done) chk({tag, " bubble"}, out_valid[k], 1'b0);
    end
    chk({tag, " use accepted"}, done, 1'b1);
    chk({tag, " bubbles"}, 64'(stalls), 64'(exp_bub));
    chk({tag, " use out"}, {out_valid[k], reg_write[k], rd[k]}, {1'b1, 1'b1, 5'd6});
    in_valid[k] = 1'b0;
    tick();
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{"lui",      32'h000010B7, 5'b00011, 2'd0, 1'b0};
    tbl[1]  = '{"auipc",    32'h00000117, 5'b00011, 2'd0, 1'b0};
    tbl[2]  = '{"addi",     32'h00100193, 5'b00011, 2'd0, 1'b0};
    tbl[3]  = '{"jal",      32'h008000EF, 5'b10011, 2'd0, 1'b0};
    tbl[4]  = '{"jalr",     32'h000100E7, 5'b10011, 2'd0, 1'b0};
    tbl[5]  = '{"beq",      32'h00208463, 5'b10010, 2'd0, 1'b0};
    tbl[6]  = '{"lw",       32'h0000A283, 5'b01111, 2'd0, 1'b0};
    tbl[7]  = '{"sb",       32'h00208023, 5'b00010, 2'd1, 1'b0};
    tbl[8]  = '{"sh",       32'h00209023, 5'b00010, 2'd2, 1'b0};
    tbl[9]  = '{"sw",       32'h0020A223, 5'b00010, 2'd3, 1'b0};
    tbl[10] = '{"st_bad",   32'h0020B023, 5'b00000, 2'd0, 1'b1};
    tbl[11] = '{"add",      32'h00228333, 5'b00001, 2'd0, 1'b0};
    tbl[12] = '{"add_x0",   32'h00208033, 5'b00000, 2'd0, 1'b0};
    tbl[13] = '{"op_7f",    32'h0000007F, 5'b00000, 2'd0, 1'b1};
    tbl[14] = '{"ecall",    32'h00000073, 5'b00000, 2'd0, 1'b0};

    idle_all();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset out_valid", out_valid[k], 1'b0);
      chk("reset outputs", got[k], 64'd0);
      chk("reset in_ready", in_ready[k], 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      in_valid[0] = 1'b1; ins[0] = tbl[i].ins;
      tick();
      chk({tbl[i].name, " valid"}, out_valid[0], 1'b1);
      chk({tbl[i].name, " ctl"}, {branch[0], mem_read[0], mem_to_reg[0], alu_src[0], reg_write[0]},
          tbl[i].ctl);
      chk({tbl[i].name, " mw/ill"}, {mem_write[0], illegal[0]}, {tbl[i].mw, tbl[i].ill});
      chk({tbl[i].name, " fields"}, {opcode[0], rd[0], rs1[0], rs2[0]},
          {tbl[i].ins[6:0], tbl[i].ins[11:7], tbl[i].ins[19:15], tbl[i].ins[24:20]});
      in_valid[0] = 1'b0;
      tick();
    end

    load_use(0, 32'h0000A283, 32'h00228333, 1, "lu1");
    load_use(1, 32'h0000A283, 32'h00228333, 3, "lu3");
    load_use(1, 32'h0000A003, 32'h00500333, 0, "lu_rd0");

    // store held while EX is busy
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; ins[0] = 32'h0020A223;
    @(negedge clk) chk("hold sw accepted", in_ready[0], 1'b1);
    tick();
    ins[0] = 32'h00100193;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk) chk("hold in_ready", in_ready[0], 1'b0);
      tick();
      chk("hold outputs", {out_valid[0], opcode[0], mem_write[0], alu_src[0]},
          {1'b1, 7'h23, 2'd3, 1'b1});
    end
    out_ready[0] = 1'b1;
    @(negedge clk) chk("hold release ready", in_ready[0], 1'b1);
    tick();
    chk("hold next loaded", {out_valid[0], opcode[0]}, {1'b1, 7'h13});
    idle_all(); tick();

    // flush during STALL
    in_valid[1] = 1'b1; ins[1] = 32'h0000A283;
    tick();
    ins[1] = 32'h00228333;
    @(negedge clk) chk("fst hazard ready", in_ready[1], 1'b0);
    tick();
    flush[1] = 1'b1;
    @(negedge clk) chk("fst flush ready", in_ready[1], 1'b0);
    tick();
    flush[1] = 1'b0;
    chk("fst flushed", out_valid[1], 1'b0);
    @(negedge clk) chk("fst run after flush", in_ready[1], 1'b1);
    tick();
    chk("fst next loaded", {out_valid[1], opcode[1]}, {1'b1, 7'h33});
    idle_all(); tick();

    // flush and hazard together
    in_valid[1] = 1'b1; ins[1] = 32'h0000A283;
    tick();
    ins[1] = 32'h00228333; flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    chk("fhz flushed", out_valid[1], 1'b0);
    @(negedge clk) chk("fhz no stall", in_ready[1], 1'b1);
    tick();
    chk("fhz loaded", out_valid[1], 1'b1);
    idle_all(); tick();

    // asynchronous reset mid-traffic and mid-STALL
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; ins[0] = 32'h0020A223;
    in_valid[1] = 1'b1; ins[1] = 32'h0000A283;
    tick();
    ins[1] = 32'h00228333;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", out_valid[0], 1'b0);
    chk("arst outputs", got[0], 64'd0);
    chk("arst in_ready", {in_ready[0], in_ready[1]}, 2'b00);
    tick();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("arst run after release", in_ready[1], 1'b1);
    tick();
    chk("arst add loaded", out_valid[1], 1'b1);
    idle_all(); tick();

`ifdef CSR_EN
    in_valid[0] = 1'b1; ins[0] = 32'h300211F3;
    tick();
    chk("csrrw", {csr_we[0], csr_addr[0], reg_write[0]}, {1'b1, 12'h300, 1'b1});
    ins[0] = 32'h300021F3;
    tick();
    chk("csrrs x0", {csr_we[0], csr_addr[0], reg_write[0]}, {1'b0, 12'h300, 1'b1});
    idle_all(); tick();
`endif

    // randomized traffic against the reference model
    rst_n = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_q[k] = '0; m_left[k] = 0;
    end
    tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        ins[k]       = rand_ins();
        flush[k]     = ($urandom_range(0, 15) == 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd in_ready[%0d] cyc %0d", k, cyc), in_ready[k], m_ready(k));
        model_step(k);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd out_valid[%0d] cyc %0d", k, cyc), out_valid[k], m_valid[k]);
        chk($sformatf("rnd outputs[%0d] cyc %0d", k, cyc), got[k], m_q[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ctrl_pipe.md
ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

Interface
REQ-001 SHALL have parameter STALL_CYC, default 1, number of bubbles inserted per load-use hazard (legal 1..3).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  IF/ID holds an instruction; in_ready  out  1  instruction accepted this cycle (combinational).
REQ-005 instruction  in  32  RV32I word; flush  in  1  EX redirect, kill ID and ID/EX contents.
REQ-006 out_valid  out  1  ID/EX register holds a real instruction; out_ready  in  1  EX consumes ID/EX this cycle.
REQ-007 Registered outputs: opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7, Branch, MemRead, MemtoReg, ALUSrc, RegWrite 1 each, MemWrite 2 (0 idle, 1 byte, 2 half, 3 word), illegal 1.
REQ-008 With CSR_EN only: csr_we  out  1, csr_addr  out  12.

Function
REQ-009 Load: in_valid && in_ready -> ID/EX register captures decoded fields and out_valid=1 next edge; latency 1 cycle.
REQ-010 Decode by opcode (Branch,MemRead,MemtoReg,ALUSrc,RegWrite): LUI/AUIPC/OP_IMM 00011, JAL/JALR 10011, BRANCH 10010, LOAD 01111, STORE 00010, OP 00001.
REQ-011 MemWrite: STORE with funct3 000/001/010 -> 1/2/3; any other funct3 or opcode -> 0.
REQ-012 RegWrite SHALL be forced 0 when rd==0.
REQ-013 Unlisted opcode (or STORE with bad funct3): all controls 0, illegal=1, out_valid=1.
REQ-014 Hold: out_valid && !out_ready -> ID/EX register unchanged, in_ready=0.
REQ-015 Hazard: out_valid && MemRead && rd!=0 && rd matches incoming rs1 (all opcodes but LUI/AUIPC/JAL) or rs2 (BRANCH/STORE/OP) -> in_ready=0 that cycle.
REQ-016 Hazard cycle with out_ready: ID/EX loads bubble (out_valid=0, controls 0); counts as bubble 1.
REQ-017 FSM states RUN, STALL; RUN->STALL on hazard cycle when STALL_CYC>1, cnt=STALL_CYC-1.
REQ-018 STALL: in_ready=0; each cycle inserts bubble and decrements cnt; cnt 1->0 returns to RUN.
REQ-019 in_ready = state==RUN && !hazard && !flush && (!out_valid || out_ready).
REQ-020 flush dominates: next edge out_valid=0, controls 0, state RUN, cnt 0; in_ready=0 that cycle.
REQ-021 flush and hazard in same cycle -> flush behaviour only, no STALL entry.

Reset
REQ-022 rst_n low SHALL immediately clear out_valid, all registered outputs (incl. csr_we, csr_addr) to 0, state RUN, cnt 0.
REQ-023 Reset mid-STALL SHALL abandon remaining bubbles; first edge after release is in RUN.
REQ-024 in_ready SHALL be 0 while rst_n low.

Configuration
REQ-025 Macro CSR_EN: defined -> SYSTEM opcode 1110011 with funct3!=0 decodes RegWrite=1 (rd!=0), csr_addr=instruction[31:20], csr_we=1 except funct3 010/011/110/111 with rs1 field 0; funct3 100 illegal.
REQ-026 CSR_EN undefined -> csr ports absent; SYSTEM decodes controls 0, illegal=0.

Verification
REQ-027 Reset: rst_n low mid-traffic -> out_valid=0, all outputs 0 asynchronously, in_ready=0.
REQ-028 lw x5,0(x1) 0x0000A283 then add x6,x5,x2 0x00228333, out_ready=1, STALL_CYC=1 -> one bubble, add valid 2 cycles after lw, RegWrite=1 rd=6.
REQ-029 Same sequence STALL_CYC=3 -> three bubbles, in_ready low 3 cycles; add x6,x0,x5 with lw rd=0 -> no stall.
REQ-030 sw x2,4(x1) 0x0020A223 with out_ready low 4 cycles -> outputs held, MemWrite=3, ALUSrc=1, in_ready=0 throughout.
REQ-031 flush asserted during STALL -> next edge out_valid=0, state RUN, next instruction accepted following cycle; opcode 0x7F -> illegal=1.
REQ-032 CSR_EN: csrrw x3,0x300,x4 0x300211F3 -> csr_we=1, csr_addr=0x300, RegWrite=1; csrrs x3,0x300,x0 -> csr_we=0.
